// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used as the serial adder datapath.
module FULL_ADDER (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with start/busy/done handshake.
// Optional signed-overflow output enabled by macro SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             cell_sum_s;
  logic             cell_cout_s;
  logic             last_bit_s;

  FULL_ADDER u_cell (
    .a     (a_sh_r[0]),
    .b     (b_sh_r[0]),
    .c_in  (carry_r),
    .sum   (cell_sum_s),
    .c_out (cell_cout_s)
  );

  // Next-state decode and last-bit detection
  always_comb begin
    state_nxt_s = state_r;
    last_bit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        last_bit_s = (cnt_r == CNT_LAST);
        if (last_bit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      done    <= (state_nxt_s == DONE);
    end
  end

  // Operand load and per-bit shifting; the carry loops back into the cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            sum_sh_r <= '0;
            carry_r  <= c_in;
            cnt_r    <= '0;
          end
        end
        SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          sum_sh_r <= {cell_sum_s, sum_sh_r[WIDTH-1:1]};
          carry_r  <= cell_cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Result registers: only updated on the final bit so they hold the previous result through SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (last_bit_s) begin
      sum   <= {cell_sum_s, sum_sh_r[WIDTH-1:1]};
      c_out <= cell_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
      // carry_r is the carry into the MSB on this edge
      ovf   <= carry_r ^ cell_cout_s;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vector table plus corner sequences,
// and a WIDTH=4 exhaustive back-to-back sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       cin8, cin4;
  logic       busy8, done8, c_out8;
  logic       busy4, done4, c_out4;
  logic [7:0] sum8;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] exp_prev;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One WIDTH=8 operation; observes timing and result for 20 cycles after accept
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output bit hold_ok);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = -1; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (lat < 0 && sum8 !== exp_prev) hold_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int   lat, bc, dc, cyc, last_done, waited;
    bit   hold, got;
    logic [3:0] av, bv;
    logic       cv;
    logic [4:0] exp5;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
    exp_prev = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_sum", {24'd0, sum8}, 32'd0);
    chk("reset_cout", {31'd0, c_out8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_ovf", {31'd0, ovf8}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc, dc, hold);
      chk("vec_sum", {24'd0, sum8}, {24'd0, vecs[i].s});
      chk("vec_cout", {31'd0, c_out8}, {31'd0, vecs[i].co});
`ifdef SERIAL_ADDER_OVF_EN
      chk("vec_ovf", {31'd0, ovf8}, {31'd0, vecs[i].ov});
`endif
      chk("vec_latency", lat, 32'd8);
      chk("vec_busy_cycles", bc, 32'd9);
      chk("vec_done_pulses", dc, 32'd1);
      chk("vec_sum_hold", {31'd0, hold}, 32'd1);
      exp_prev = vecs[i].s;
    end

    // Reset during the 4th SHIFT cycle; previous result 0x47 must vanish at once
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_done", {31'd0, done8}, 32'd0);
    chk("midrst_sum", {24'd0, sum8}, 32'd0);
    chk("midrst_cout", {31'd0, c_out8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", {31'd0, ovf8}, 32'd0);
`endif
    dc = 0;
    repeat (4) begin
      @(negedge clk);
      if (done8) dc++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) dc++;
    end
    chk("midrst_no_done", dc, 32'd0);
    exp_prev = 8'h00;
    run_op8(8'h03, 8'h04, 1'b0, lat, bc, dc, hold);
    chk("after_rst_sum", {24'd0, sum8}, 32'h07);
    chk("after_rst_cout", {31'd0, c_out8}, 32'd0);
    chk("after_rst_latency", lat, 32'd8);
    exp_prev = 8'h07;

    // Input isolation: operands change and start re-pulses mid-SHIFT
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dc = 0;
    for (int k = 0; k < 25; k++) begin
      if (done8) dc++;
      @(negedge clk);
    end
    chk("iso_done_pulses", dc, 32'd1);
    chk("iso_sum", {24'd0, sum8}, 32'h00);
    chk("iso_cout", {31'd0, c_out8}, 32'd1);
    chk("iso_busy_idle", {31'd0, busy8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("iso_ovf", {31'd0, ovf8}, 32'd0);
`endif

    // WIDTH=4 exhaustive sweep with start held high
    cyc = 0;
    last_done = 0;
    @(negedge clk);
    start4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      {cv, av, bv} = 9'(i);
      a4 = av; b4 = bv; cin4 = cv;
      got = 1'b0;
      waited = 0;
      while (!got && waited < 12) begin
        @(negedge clk);
        cyc++;
        waited++;
        if (done4) got = 1'b1;
      end
      exp5 = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
      chk("sweep_done_seen", {31'd0, got}, 32'd1);
      chk("sweep_result", {27'd0, c_out4, sum4}, {27'd0, exp5});
`ifdef SERIAL_ADDER_OVF_EN
      chk("sweep_ovf", {31'd0, ovf4},
          {31'd0, (av[3] == bv[3]) && (exp5[3] != av[3])});
`endif
      if (i == 0) chk("sweep_first_latency", waited, 32'd5);
      else        chk("sweep_spacing", cyc - last_done, 32'd6);
      last_done = cyc;
    end
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("sweep_end_idle", {31'd0, busy4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that uses the single-bit `FULL_ADDER` cell as its datapath and adds two WIDTH-bit operands LSB-first, one bit per clock. It sits directly downstream of the full-adder cell. It supplies the per-bit operands and carry-in, registers the cell's carry-out back into the next bit, and assembles the sum bits into a registered result word. A start/busy/done handshake lets a controller launch one addition and collect its result.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; must be at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to launch an addition; only acted on in IDLE.
- `a`  in  WIDTH  operand A, sampled only on the accepting edge.
- `b`  in  WIDTH  operand B, sampled only on the accepting edge.
- `c_in`  in  1  initial carry, sampled only on the accepting edge.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse; result is valid from this cycle on.
- `sum`  out  WIDTH  registered result; holds its value until the next DONE.
- `c_out`  out  1  registered final carry; holds like `sum`.
- `ovf`  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM with states IDLE, SHIFT and DONE.
- **IDLE**
  - `start`=1 at an edge: load `a_sh`←`a`, `b_sh`←`b`, `carry`←`c_in`, `cnt`←0; go to SHIFT.
  - `start`=0: stay in IDLE.
- **SHIFT**, one bit per edge:
  - The cell sees `a_sh[0]`, `b_sh[0]` and `carry`.
  - The cell sum bit shifts into the MSB of `sum_sh`; `sum_sh` shifts right.
  - `a_sh` and `b_sh` shift right; `carry`←cell `c_out`; `cnt`++.
  - On the edge where `cnt`==WIDTH-1, go to DONE. On that same edge, copy the completed sum word (including that edge's bit) to `sum` and the final cell `c_out` to `c_out`.
- **DONE**: `done`=1 for exactly one cycle; go to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE, with no queueing. `a`, `b` and `c_in` changes after acceptance have no effect.
- The counter is $clog2(WIDTH) bits wide. The sum is modulo 2^WIDTH, and `c_out` carries the bit-WIDTH overflow. The result equals a+b+c_in exactly.
- Reset mid-operation discards the partial result. The next `start` after reset release behaves normally.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `c_out`=0, `ovf`=0; state IDLE; all shift registers, `carry` and `cnt` are 0.
- Reset is asynchronous on the assert side; outputs clear without waiting for a clock edge.
- Call the accepting edge E0.
  - `busy` rises after E0.
  - Bits are processed on edges E1..EWIDTH.
  - `sum`/`c_out` update and `done` goes high after EWIDTH.
  - `done` and `busy` fall after E(WIDTH+1).
- Latency from accept to `done` is WIDTH cycles.
- With `start` held high continuously, throughput is one operation per WIDTH+2 cycles; the next accept is at E(WIDTH+2).
- `sum`/`c_out` are stable throughout SHIFT and show the previous result until the new one lands.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - On the last SHIFT edge, `ovf`←(carry into MSB) XOR (carry out of MSB); it holds like `sum`.
- Undefined: port `ovf` and its register are absent; all other behaviour is identical.

## Structure
- Package `serial_adder_pkg`:
  - typedef `state_t` enum {IDLE, SHIFT, DONE};
  - constant `SERIAL_ADDER_DEFAULT_WIDTH`=8.
- One sub-module: the existing `FULL_ADDER` is instantiated once as the bit cell. The FSM, counter and shift registers live in `serial_adder`.

## Test plan
- **Zero add**: WIDTH=8, a=0x00, b=0x00, c_in=0, start pulse → `done` 8 cycles after accept; `sum`=0x00, `c_out`=0, `busy` high for 9 cycles.
- **Carry ripple**: a=0xFF, b=0x01, c_in=0 → `sum`=0x00, `c_out`=1, `ovf`=0.
- **Signed overflow**: a=0x7F, b=0x01, c_in=0 → `sum`=0x80, `c_out`=0, `ovf`=1. Without the macro, the bench compiles with no `ovf` and sum/c_out are unchanged.
- **Input isolation**: a=0xA5, b=0x5A, c_in=1; change a/b to 0x00 and pulse `start` again mid-SHIFT → `sum`=0x00, `c_out`=1; exactly one `done` pulse.
- **Reset mid-operation**: `rst_n` low during the 4th SHIFT cycle → all outputs 0 immediately, no `done`. After release, a=0x03, b=0x04, c_in=0 → `sum`=0x07.
- **Exhaustive sweep**: WIDTH=4, all a/b/c_in combinations with `start` held high → each result equals a+b+c_in; consecutive `done` pulses 6 cycles apart.
